// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write bus and load status of the boot loader.
// The master side feeds bytes and observes writes; the loader sits on the slave side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [6:0]        word_cnt;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error, word_cnt
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, cpu_rst, done, error, word_cnt
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame, writes big-endian words
// into instruction memory and holds the datapath in reset until the frame checks out.
//
//   state    | meaning
//   S_LEN_HI | waiting for length high byte; running sum cleared
//   S_LEN_LO | waiting for length low byte; length range checked
//   S_DATA   | assembling payload words, one write per 4 bytes
//   S_CSUM   | waiting for checksum byte
//   S_DONE   | load good, datapath released (terminal)
//   S_ERR    | bad length or checksum, datapath held (terminal)
module imem_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = 8
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [7:0]        len_hi;
  logic [15:0]       last_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic [7:0]        sum;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [6:0]        word_cnt;

  logic              in_ready;
  logic              xfer;
  logic [15:0]       len_full;
  logic              len_ok;
  logic [7:0]        sum_nxt;
  logic              last_byte;

  assign xfer      = bus.in_valid && in_ready;
  assign len_full  = {len_hi, bus.in_data};
  assign len_ok    = (len_full != 16'd0) && (len_full <= 16'(DEPTH_WORDS));
  assign sum_nxt   = sum + bus.in_data;
  assign last_byte = (byte_cnt == 2'd3) && ({9'd0, word_cnt} == last_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LEN_HI;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) state_nxt = len_ok ? S_DATA : S_ERR;
      S_DATA:   if (xfer && last_byte) state_nxt = S_CSUM;
      S_CSUM:   if (xfer) state_nxt = (sum_nxt == 8'd0) ? S_DONE : S_ERR;
      default:  state_nxt = state;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: in_ready = 1'b1;
      default:                            in_ready = 1'b0;
    endcase
  end

  // word_cnt doubles as the index of the word being assembled
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi   <= '0;
      last_idx <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      sum      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      word_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == S_LEN_HI) sum <= '0;
      if (xfer) begin
        case (state)
          S_LEN_HI: len_hi <= bus.in_data;
          S_LEN_LO: begin
            last_idx <= len_full - 16'd1;
            byte_cnt <= '0;
          end
          S_DATA: begin
            sum      <= sum_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              wr_data  <= {asm_q, bus.in_data};
              wr_addr  <= ADDR_W'({word_cnt, 2'b00});
              word_cnt <= word_cnt + 7'd1;
            end else begin
              asm_q <= {asm_q[15:0], bus.in_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.word_cnt = word_cnt;
  assign bus.done     = (state == S_DONE);
  assign bus.error    = (state == S_ERR);
  assign bus.cpu_rst  = (state != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame bench: a frame-level reference model queues expected writes and
// final status; a negedge monitor pops and compares every write the loader issues.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [6:0]  cnt;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  wr_t  sb[$];

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.DEPTH_WORDS(64), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        chk("wr_data", bus.wr_data, e.data);
        chk("wr_word_cnt", 32'(bus.word_cnt), 32'(e.cnt));
      end
    end
  end

  // Frame-level model: expected writes and the final verdict from the frame rules
  task automatic model_frame(input bq_t b, output logic ed, output logic ee,
                             output logic [6:0] ec);
    int n;
    logic [7:0] s;
    wr_t w;
    n = {b[0], b[1]};
    if (n < 1 || n > 64) begin
      ed = 1'b0; ee = 1'b1; ec = 7'd0;
      return;
    end
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      w.addr = 8'(i * 4);
      w.data = {b[2+4*i], b[3+4*i], b[4+4*i], b[5+4*i]};
      w.cnt  = 7'(i + 1);
      sb.push_back(w);
      for (int k = 0; k < 4; k++) s = s + b[2+4*i+k];
    end
    ed = ((s + b[2+4*n]) == 8'd0);
    ee = !ed;
    ec = 7'(n);
  endtask

  task automatic build_frame(input int n, input logic [31:0] words[$], input logic bad,
                             output bq_t b);
    logic [7:0] s;
    logic [31:0] w;
    b = {};
    b.push_back(n[15:8]);
    b.push_back(n[7:0]);
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = (i < words.size()) ? words[i] : $urandom;
      for (int k = 3; k >= 0; k--) begin
        b.push_back(w[8*k +: 8]);
        s = s + w[8*k +: 8];
      end
    end
    s = 8'd0 - s;
    if (bad) s = s + 8'd1;
    b.push_back(s);
  endtask

  task automatic send(input bq_t b, input int first, input int last, input int gap_max);
    for (int i = first; i <= last; i++) begin
      int g;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_end(input string tag, input logic ed, input logic ee,
                           input logic [6:0] ec);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(bus.done), 32'(ed));
    chk({tag, "_error"}, 32'(bus.error), 32'(ee));
    chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'(!ed));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(0));
    chk({tag, "_word_cnt"}, 32'(bus.word_cnt), 32'(ec));
    chk({tag, "_pending_writes"}, 32'(sb.size()), 32'(0));
  endtask

  task automatic run_frame(input string tag, input bq_t b, input int gap_max);
    logic ed, ee;
    logic [6:0] ec;
    do_reset();
    model_frame(b, ed, ee, ec);
    send(b, 0, b.size() - 1, gap_max);
    check_end(tag, ed, ee, ec);
  endtask

  initial begin
    bq_t b, junk;
    logic [31:0] ws[$];
    logic ed, ee;
    logic [6:0] ec;
    int start;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_wr_en", 32'(bus.wr_en), 32'(0));
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'(0));
    chk("rst_wr_data", bus.wr_data, 32'(0));
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'(1));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_error", 32'(bus.error), 32'(0));
    chk("rst_word_cnt", 32'(bus.word_cnt), 32'(0));

    // reference N=2 frame at full rate, with done latency checked
    ws = '{32'h20080005, 32'h01095020};
    build_frame(2, ws, 1'b0, b);
    do_reset();
    model_frame(b, ed, ee, ec);
    start = cyc;
    send(b, 0, 9, 0);
    chk("n2_done_before_csum", 32'(bus.done), 32'(0));
    chk("n2_cpu_rst_before_csum", 32'(bus.cpu_rst), 32'(1));
    send(b, 10, 10, 0);
    chk("n2_done_latency", 32'(bus.done), 32'(1));
    chk("n2_cpu_rst_latency", 32'(bus.cpu_rst), 32'(0));
    chk("n2_edges_to_done", 32'(cyc - start), 32'(11));
    check_end("n2", ed, ee, ec);

    // corrupted checksum, then more bytes that must be ignored
    build_frame(2, ws, 1'b1, b);
    junk = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_reset();
    model_frame(b, ed, ee, ec);
    send(b, 0, b.size() - 1, 0);
    send(junk, 0, junk.size() - 1, 0);
    check_end("bad_csum", ed, ee, ec);

    // out-of-range lengths
    b = '{8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    do_reset();
    model_frame(b, ed, ee, ec);
    send(b, 0, 1, 0);
    chk("len0_error_after_lo", 32'(bus.error), 32'(1));
    send(b, 2, b.size() - 1, 0);
    check_end("len0", ed, ee, ec);
    b = '{8'h00, 8'h41, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    do_reset();
    model_frame(b, ed, ee, ec);
    send(b, 0, 1, 0);
    chk("len65_error_after_lo", 32'(bus.error), 32'(1));
    send(b, 2, b.size() - 1, 0);
    check_end("len65", ed, ee, ec);

    // full capacity
    ws = {};
    build_frame(64, ws, 1'b0, b);
    run_frame("n64", b, 0);

    // gapped reference frame
    ws = '{32'h20080005, 32'h01095020};
    for (int r = 0; r < 4; r++) begin
      build_frame(2, ws, 1'b0, b);
      run_frame("n2_gaps", b, 5);
    end

    // reset pulsed after the 6th byte; the first word's write is already in flight
    build_frame(2, ws, 1'b0, b);
    do_reset();
    begin
      wr_t w;
      w.addr = 8'h00;
      w.data = {b[2], b[3], b[4], b[5]};
      w.cnt  = 7'd1;
      sb.push_back(w);
    end
    send(b, 0, 5, 0);
    do_reset();
    chk("midrst_word_cnt", 32'(bus.word_cnt), 32'(0));
    chk("midrst_cpu_rst", 32'(bus.cpu_rst), 32'(1));
    chk("midrst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("midrst_done", 32'(bus.done), 32'(0));
    ws = {};
    build_frame(1, ws, 1'b0, b);
    model_frame(b, ed, ee, ec);
    send(b, 0, b.size() - 1, 0);
    check_end("midrst_n1", ed, ee, ec);

    // random frames, some with bad checksum
    for (int r = 0; r < 8; r++) begin
      ws = {};
      build_frame(int'($urandom_range(1, 8)), ws, ($urandom_range(0, 2) == 0), b);
      run_frame("rand", b, 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
